// File: rtl/bidir_switch_ctrl_if.sv
// Control bundle for one bidirectional routing switch.
//   req_on/req_dir : level request from configuration logic (master -> slave)
//   en_fwd/en_rev  : registered driver enables (slave -> master)
//   busy           : turnaround dead time in progress
//   dir_changes    : saturating count of completed reversals
interface bidir_switch_ctrl_if;
    logic       req_on;
    logic       req_dir;
    logic       en_fwd;
    logic       en_rev;
    logic       busy;
    logic [7:0] dir_changes;

    modport master (output req_on, req_dir, input en_fwd, en_rev, busy, dir_changes);
    modport slave  (input req_on, req_dir, output en_fwd, en_rev, busy, dir_changes);
endinterface

// File: rtl/bidir_switch_ctrl.sv
// Direction-controlled bidirectional switch between two fabric wires.
// Drives port2 from port1 (FWD), port1 from port2 (REV), or neither.
// Every reversal passes through a DEAD_CYCLES break-before-make window.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : control bundle (slave side), see bidir_switch_ctrl_if
//   port1      : fabric wire A, driven only in REV
//   port2      : fabric wire B, driven only in FWD
module bidir_switch_ctrl #(
    parameter int DEAD_CYCLES = 2,
    parameter int CNT_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bidir_switch_ctrl_if.slave        bus,
    inout  wire                       port1,
    inout  wire                       port2
);

    typedef enum logic [1:0] {S_OFF, S_FWD, S_REV, S_TURN} state_t;

    state_t           state_q;
    logic             en_fwd_q, en_rev_q, busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tgt_q;   // 1 = FWD, 0 = REV
    logic             prev_q;  // direction held before entering TURN
    logic [7:0]       chg_q;
    logic [7:0]       chg_d;

    assign chg_d = (chg_q == 8'hFF) ? chg_q : chg_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_OFF;
            en_fwd_q <= 1'b0;
            en_rev_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            tgt_q    <= 1'b1;
            prev_q   <= 1'b1;
            chg_q    <= 8'd0;
        end else begin
            case (state_q)
                S_OFF: begin
                    // Nothing is driven, so no dead time is needed.
                    if (bus.req_on) begin
                        state_q  <= bus.req_dir ? S_FWD : S_REV;
                        en_fwd_q <= bus.req_dir;
                        en_rev_q <= !bus.req_dir;
                    end
                end
                S_FWD, S_REV: begin
                    if (!bus.req_on) begin
                        state_q  <= S_OFF;
                        en_fwd_q <= 1'b0;
                        en_rev_q <= 1'b0;
                    end else if (bus.req_dir != (state_q == S_FWD)) begin
                        state_q  <= S_TURN;
                        en_fwd_q <= 1'b0;
                        en_rev_q <= 1'b0;
                        busy_q   <= 1'b1;
                        tgt_q    <= bus.req_dir;
                        prev_q   <= (state_q == S_FWD);
                        cnt_q    <= CNT_W'(DEAD_CYCLES);
                    end
                end
                S_TURN: begin
                    if (!bus.req_on) begin
                        // Abort: no reversal completed, count untouched.
                        state_q <= S_OFF;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        // Target follows the request each cycle; the dead
                        // time is not restarted by a retarget.
                        tgt_q <= bus.req_dir;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q  <= bus.req_dir ? S_FWD : S_REV;
                            en_fwd_q <= bus.req_dir;
                            en_rev_q <= !bus.req_dir;
                            busy_q   <= 1'b0;
                            cnt_q    <= '0;
                            if (bus.req_dir != prev_q) chg_q <= chg_d;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q  <= S_OFF;
                    en_fwd_q <= 1'b0;
                    en_rev_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en_fwd      = en_fwd_q;
    assign bus.en_rev      = en_rev_q;
    assign bus.busy        = busy_q;
    assign bus.dir_changes = chg_q;

    // Data path is purely combinational off the registered enables.
    assign port2 = en_fwd_q ? port1 : 1'bz;
    assign port1 = en_rev_q ? port2 : 1'bz;

endmodule

// File: tb/tb_bidir_switch_ctrl.sv
// Scoreboard bench for bidir_switch_ctrl (DEAD_CYCLES=2).
// Driver applies inputs on the falling edge and queues the expected
// registered outputs for the following rising edge; the monitor pops and
// compares just after each rising edge.
module tb_bidir_switch_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bidir_switch_ctrl_if bus();

    wire  port1, port2;
    logic p1_en, p1_val, p2_en, p2_val;
    assign port1 = p1_en ? p1_val : 1'bz;
    assign port2 = p2_en ? p2_val : 1'bz;

    bidir_switch_ctrl #(.DEAD_CYCLES(2), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .port1 (port1),
        .port2 (port2)
    );

    typedef struct {
        logic       ef;
        logic       er;
        logic       bz;
        logic [7:0] dc;
        string      nm;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor: one expected entry per clocked step.
    always @(posedge clk) begin
        exp_t e;
        #1;
        total++;
        if (bus.en_fwd && bus.en_rev) begin
            bad++;
            $display("FAIL excl: en_fwd=1 en_rev=1 both set at %0t", $time);
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            total++;
            if (bus.en_fwd !== e.ef || bus.en_rev !== e.er || bus.busy !== e.bz ||
                bus.dir_changes !== e.dc) begin
                bad++;
                $display("FAIL %s: got ef=%b er=%b busy=%b dc=%0d want ef=%b er=%b busy=%b dc=%0d",
                         e.nm, bus.en_fwd, bus.en_rev, bus.busy, bus.dir_changes,
                         e.ef, e.er, e.bz, e.dc);
            end
        end
    end

    task automatic step(input logic rn, on, dir, input logic ef, er, bz,
                        input logic [7:0] dc, input string nm);
        exp_t e;
        @(negedge clk);
        rst_n       = rn;
        bus.req_on  = on;
        bus.req_dir = dir;
        e.ef = ef; e.er = er; e.bz = bz; e.dc = dc; e.nm = nm;
        sb_q.push_back(e);
    endtask

    // Let the pending edge land, then probe the data path mid-cycle.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic cmp1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic cmp_not1(input string nm, input logic act);
        total++;
        if (act === 1'b1) begin
            bad++;
            $display("FAIL %s: got %b want not driven high", nm, act);
        end
    endtask

    initial begin
        logic       d;
        logic [7:0] pc, nc;
        rst_n = 1'b0; bus.req_on = 1'b0; bus.req_dir = 1'b0;
        p1_en = 1'b0; p1_val = 1'b0; p2_en = 1'b0; p2_val = 1'b0;

        step(0, 0, 0, 0, 0, 0, 8'd0, "reset");
        step(1, 0, 1, 0, 0, 0, 8'd0, "idle");

        // FWD on, port2 follows port1
        step(1, 1, 1, 1, 0, 0, 8'd0, "fwd_on");
        settle();
        p1_en = 1'b1; p1_val = 1'b1; #1; cmp1("fwd_p2_hi", port2, 1'b1);
        p1_val = 1'b0; #1;              cmp1("fwd_p2_lo", port2, 1'b0);
        step(1, 1, 1, 1, 0, 0, 8'd0, "fwd_hold");

        // Reversal with two dead cycles
        step(1, 1, 0, 0, 0, 1, 8'd0, "turn1");
        settle();
        p1_val = 1'b1; #1; cmp_not1("turn_p2_off", port2);
        step(1, 1, 0, 0, 0, 1, 8'd0, "turn2");
        step(1, 1, 0, 0, 1, 0, 8'd1, "rev");
        settle();
        p1_en = 1'b0; p2_en = 1'b1; p2_val = 1'b1; #1; cmp1("rev_p1_hi", port1, 1'b1);
        p2_val = 1'b0; #1;                               cmp1("rev_p1_lo", port1, 1'b0);
        p2_en = 1'b0;

        // Abort during second TURN cycle
        step(1, 1, 1, 0, 0, 1, 8'd1, "ab_turn1");
        step(1, 0, 1, 0, 0, 0, 8'd1, "abort");
        step(1, 1, 0, 0, 1, 0, 8'd1, "rev_again");

        // Retarget back to FWD mid-TURN
        step(1, 0, 0, 0, 0, 0, 8'd1, "off");
        step(1, 1, 1, 1, 0, 0, 8'd1, "fwd2");
        step(1, 1, 0, 0, 0, 1, 8'd1, "rt_turn1");
        step(1, 1, 1, 0, 0, 1, 8'd1, "rt_turn2");
        step(1, 1, 1, 1, 0, 0, 8'd1, "rt_back");

        // Reset mid-TURN
        step(1, 1, 0, 0, 0, 1, 8'd1, "t5_turn");
        step(0, 1, 0, 0, 0, 0, 8'd0, "rst_mid");
        settle();
        p1_en = 1'b1; p1_val = 1'b1; #1; cmp_not1("rst_p2_off", port2);
        p1_en = 1'b0; p2_en = 1'b1; p2_val = 1'b1; #1; cmp_not1("rst_p1_off", port1);
        p2_en = 1'b0;
        step(1, 0, 1, 0, 0, 0, 8'd0, "post_rst");

        // Saturation: 260 alternating reversals
        step(1, 1, 1, 1, 0, 0, 8'd0, "sat_fwd");
        for (int i = 1; i <= 260; i++) begin
            d  = i[0] ? 1'b0 : 1'b1;
            pc = 8'(((i - 1) > 255) ? 255 : (i - 1));
            nc = 8'((i > 255) ? 255 : i);
            step(1, 1, d, 0, 0, 1, pc, "sat_turn1");
            step(1, 1, d, 0, 0, 1, pc, "sat_turn2");
            step(1, 1, d, d, !d, 0, nc, "sat_end");
        end
        step(1, 1, 1, 1, 0, 0, 8'd255, "sat_hold1");
        step(1, 0, 1, 0, 0, 0, 8'd255, "sat_hold2");
        step(1, 0, 1, 0, 0, 0, 8'd255, "sat_hold3");

        @(posedge clk);
        #3;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bidir_switch_ctrl.md
# bidir_switch_ctrl

Direction-controlled bidirectional routing switch for the emulator fabric. It connects two fabric wires and drives exactly one of them at a time (port1→port2 or port2→port1), or neither. Every direction reversal passes through a break-before-make dead time so the two drivers never overlap. Each instance is controlled by the configuration logic through a level request pair and reports its turnaround status and a count of completed reversals.

## Interface

- DEAD_CYCLES, 2, number of cycles both drivers are off during a reversal; legal range 1..15
- CNT_W, 4, width of the dead-time counter; must hold DEAD_CYCLES
- clk  input  1  fabric clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous, active-low
- req_on  input  1  1 = switch requested on, 0 = requested off (level)
- req_dir  input  1  requested direction: 1 = port1→port2 (FWD), 0 = port2→port1 (REV)
- port1  inout  1  fabric wire A; driven only in REV, otherwise high-Z
- port2  inout  1  fabric wire B; driven only in FWD, otherwise high-Z
- en_fwd  output  1  registered; 1 iff state is FWD
- en_rev  output  1  registered; 1 iff state is REV
- busy  output  1  registered; 1 iff state is TURN
- dir_changes  output  8  completed reversals; saturating counter

## Operation

- States:
  - OFF: no port driven.
  - FWD: port2 = port1, port1 = Z.
  - REV: port1 = port2, port2 = Z.
  - TURN: no port driven; dead-time countdown running.
- Port drivers are combinational from the registered enables:
  - port2 = en_fwd ? port1 : Z
  - port1 = en_rev ? port2 : Z
- Transitions, evaluated at each rising edge:
  - OFF:
    - req_on=1 → FWD if req_dir=1, REV if req_dir=0.
    - Otherwise stay in OFF.
    - No dead time is applied, because nothing is driven.
  - FWD:
    - req_on=0 → OFF.
    - req_on=1 and req_dir=0 → TURN: target ← REV, cnt ← DEAD_CYCLES.
    - Otherwise hold.
  - REV: mirror of FWD (req_dir=1 → TURN with target ← FWD).
  - TURN:
    - req_on=0 → OFF (abort); cnt cleared; dir_changes not incremented.
    - Otherwise target ← req_dir on every cycle, so the target can be retargeted without restarting cnt.
    - If cnt==1: go to target and increment dir_changes, but only when target differs from the direction held before TURN. Otherwise go to target with no increment.
    - If cnt≠1: cnt ← cnt−1.
- The enables are never both 1. TURN and OFF have both enables at 0.
- dir_changes saturates at 255 and holds there. It is cleared only by reset.
- Reset (rst_n=0 at an edge) takes effect from any state, including mid-TURN. After reset:
  - state OFF
  - en_fwd=0, en_rev=0, busy=0
  - cnt=0, target=FWD, dir_changes=0
  - port1 and port2 high-Z

## Timing

- The request is sampled at edge k, and the enables reflect it after edge k. Latency from OFF to a driven port is 1 edge.
- Reversal requested at edge k (FWD, req_dir→0):
  - en_fwd=0 and busy=1 after edge k.
  - busy stays 1 for exactly DEAD_CYCLES cycles.
  - en_rev=1 and busy=0 after edge k+DEAD_CYCLES.
  - dir_changes increments at that same edge.
- Turning off (req_on→0) from FWD, REV or TURN: all enables are 0 after 1 edge.
- Outputs are glitch-free registered levels. The port data path has combinational delay only, with no cycle latency.

## Test plan

1. Reset, then req_on=1, req_dir=1 at edge 1 → en_fwd=1 after edge 1. Drive port1=1 then 0 → port2 follows; port1 is not driven by the block.
2. From FWD with DEAD_CYCLES=2, set req_dir=0 at edge k:
   - after edges k and k+1: en_fwd=en_rev=0 and busy=1
   - after edge k+2: en_rev=1, busy=0, dir_changes=1
   - port1 follows port2
3. Abort: set req_on=0 during TURN (second cycle) → OFF next edge, busy=0, dir_changes unchanged. Then req_on=1, req_dir=0 → REV after 1 edge.
4. Retarget: in FWD set req_dir=0, then set req_dir back to 1 during TURN → returns to FWD after DEAD_CYCLES total cycles; dir_changes unchanged.
5. Reset mid-TURN: assert rst_n=0 for one edge → all outputs 0, ports high-Z, dir_changes=0.
6. Saturation: perform 260 reversals → dir_changes reads 255 and holds; en_fwd and en_rev are never both 1 at any cycle (assertion active throughout all tests).
